// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator controller and its call panel front end.
package elevator_pkg;

  localparam int unsigned DefaultFloors = 5;
  localparam int unsigned DefaultPosW   = 3;
  localparam int unsigned DefaultDbCycles = 4;

  // Counter width that holds 0..cycles-1 for a debounce window of 'cycles'.
  function automatic int unsigned db_w(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles + 1);
  endfunction

  localparam int unsigned DefaultDbW = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StUp   = 2'd1,
    StDn   = 2'd2,
    StDoor = 2'd3
  } elev_state_e;

endpackage

// File: rtl/call_debounce.sv
// One call button bit: optional 2-flop synchroniser (CALL_PANEL_SYNC_EN), sample flop,
// counter-based debounce; rise pulses on the edge where the debounced level goes 0->1.
module call_debounce
  import elevator_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDbCycles,
  parameter int unsigned DB_W            = DefaultDbW
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  localparam logic [DB_W-1:0] CntLast = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            btn_in;
  logic            s_q;
  logic            db_q, db_d;
  logic [DB_W-1:0] cnt_q, cnt_d;

`ifdef CALL_PANEL_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], btn};
    end
  end

  assign btn_in = sync_q[1];
`else
  assign btn_in = btn;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q   <= 1'b0;
      db_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s_q   <= btn_in;
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end

  // Any return to the accepted level restarts the window, rejecting short glitches.
  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    if (s_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      db_d  = s_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DB_W'(1);
    end
  end

  assign rise = db_d & ~db_q & ~reset;

endmodule

// File: rtl/call_panel.sv
// Call panel front end: debounces per-floor buttons, issues one-cycle floor requests and keeps
// call lamps that clear when the door opens at that floor. Optional macro: CALL_PANEL_SYNC_EN.
module call_panel
  import elevator_pkg::*;
#(
  parameter int unsigned FLOORS          = DefaultFloors,
  parameter int unsigned POS_W           = DefaultPosW,
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDbCycles,
  parameter int unsigned DB_W            = DefaultDbW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLOORS-1:0] btn,
  input  logic [POS_W-1:0]  floor_pos,
  input  logic              door_open,
  output logic [FLOORS-1:0] floor_req,
  output logic [FLOORS-1:0] call_lamp
);

  logic [FLOORS-1:0] rise;
  logic [FLOORS-1:0] serve;

  for (genvar g = 0; g < FLOORS; g++) begin : gen_db
    call_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .DB_W            (DB_W)
    ) u_db (
      .clk   (clk),
      .reset (reset),
      .btn   (btn[g]),
      .rise  (rise[g])
    );
  end

  // Out-of-range positions match no floor, so no lamp is cleared.
  always_comb begin
    serve = '0;
    for (int i = 0; i < FLOORS; i++) begin
      serve[i] = door_open && (floor_pos == POS_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      floor_req <= '0;
      call_lamp <= '0;
    end else begin
      floor_req <= rise & ~call_lamp & ~serve;
      // Clear beats a simultaneous press, absorbing presses at an open door.
      call_lamp <= ~serve & (call_lamp | rise);
    end
  end

endmodule
